// File: rtl/regfile_writeback.sv
// Register-file write-back arbiter: single-cycle ALU results take the write
// port directly, multiply/divide results queue in a small FIFO and drain on
// cycles the ALU leaves free. An ALU write kills any queued md entry for the
// same register so a stale result can never overwrite a newer one.

package regfile_writeback_pkg;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              live;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } md_entry_t;
endpackage

module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              alu_valid,
  input  logic [RD_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              md_valid,
  input  logic [RD_W-1:0]   md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              ctrl_writeEnable,
  output logic [RD_W-1:0]   ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic [DATA_W-1:0] md_pending
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  md_entry_t         fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic      alu_wr_c;
  logic      push_c;
  logic      pop_c;
  logic      incoming_live_c;
  md_entry_t head_c;

  // Source selection and FIFO handshake decode
  always_comb begin
    alu_wr_c        = alu_valid && (alu_rd != '0);
    md_ready        = (count < CNT_W'(DEPTH));
    push_c          = md_valid && md_ready && (md_rd != '0);
    pop_c           = !alu_wr_c && (count != '0);
    incoming_live_c = !(alu_wr_c && (alu_rd == md_rd));
    head_c          = fifo_q[rd_ptr];
  end

  // Write-port register, FIFO storage, pointers and kill tracking
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (alu_wr_c) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= alu_rd;
        data_writeReg    <= alu_data;
      end else if (pop_c) begin
        // A dead head still uses this slot but produces no write
        ctrl_writeEnable <= head_c.live;
        ctrl_writeReg    <= head_c.live ? head_c.rd : '0;
        data_writeReg    <= head_c.live ? head_c.data : '0;
      end else begin
        ctrl_writeEnable <= 1'b0;
        ctrl_writeReg    <= '0;
        data_writeReg    <= '0;
      end

      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (alu_wr_c && (fifo_q[i].rd == alu_rd)) begin
          fifo_q[i].live <= 1'b0;
        end
      end

      // Pop and push never share a slot: pop needs count>0, push needs count<DEPTH
      if (pop_c) begin
        fifo_q[rd_ptr].live <= 1'b0;
        rd_ptr              <= rd_ptr + PTR_W'(1);
      end

      if (push_c) begin
        fifo_q[wr_ptr] <= '{live: incoming_live_c, rd: md_rd, data: md_data};
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end

      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Scoreboard of registers with a live md result still queued
  always_comb begin
    md_pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_q[i].live) begin
        md_pending[fifo_q[i].rd] = 1'b1;
      end
    end
    md_pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus a write-port monitor
// that matches every write against expected ALU and md queues.

module tb_regfile_writeback;

  logic        clock;
  logic        ctrl_reset_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [31:0] md_pending;

  regfile_writeback #(.DEPTH(4)) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .alu_valid        (alu_valid),
    .alu_rd           (alu_rd),
    .alu_data         (alu_data),
    .md_valid         (md_valid),
    .md_rd            (md_rd),
    .md_data          (md_data),
    .md_ready         (md_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .md_pending       (md_pending)
  );

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t alu_q[$];
  exp_t md_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Write-port monitor: ALU writes are due exactly one cycle after issue,
  // md writes follow acceptance order no earlier than two cycles later
  always @(negedge clock) begin
    if (ctrl_reset_n === 1'b1) begin
      while (alu_q.size() > 0 && alu_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL alu_missed: reg %0d data %h due cycle %0d not written", alu_q[0].rd, alu_q[0].data, alu_q[0].cyc);
        void'(alu_q.pop_front());
      end
      if (alu_q.size() > 0 && alu_q[0].cyc == cyc) begin
        mon_e = alu_q.pop_front();
        checks++;
        if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== mon_e.rd || data_writeReg !== mon_e.data) begin
          errors++;
          $display("FAIL alu_write: cycle %0d got we=%b reg=%0d data=%h, expected we=1 reg=%0d data=%h",
                   cyc, ctrl_writeEnable, ctrl_writeReg, data_writeReg, mon_e.rd, mon_e.data);
        end
      end else if (ctrl_writeEnable !== 1'b0) begin
        checks++;
        if (md_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: cycle %0d got we=%b reg=%0d data=%h, expected no write",
                   cyc, ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end else begin
          mon_e = md_q.pop_front();
          if (ctrl_writeReg !== mon_e.rd || data_writeReg !== mon_e.data || cyc < mon_e.cyc + 2) begin
            errors++;
            $display("FAIL md_write: cycle %0d got reg=%0d data=%h, expected reg=%0d data=%h no earlier than cycle %0d",
                     cyc, ctrl_writeReg, data_writeReg, mon_e.rd, mon_e.data, mon_e.cyc + 2);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives the md port; an expected-accepted nonzero entry is queued for the monitor
  task automatic drive_md(input logic v, input logic [4:0] rd, input logic [31:0] d, input bit accept);
    md_valid = v;
    md_rd    = rd;
    md_data  = d;
    if (v && accept && rd != 5'd0) md_q.push_back('{cyc, rd, d});
  endtask

  // Drives the ALU port; a nonzero write is expected next cycle and kills matching md entries
  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
    if (v && rd != 5'd0) begin
      alu_q.push_back('{cyc + 1, rd, d});
      for (int i = md_q.size() - 1; i >= 0; i--) begin
        if (md_q[i].rd == rd) md_q.delete(i);
      end
    end
  endtask

  task automatic wait_drain(input string name);
    drive_md(1'b0, 5'd0, 32'd0, 1'b0);
    drive_alu(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 40 && (alu_q.size() > 0 || md_q.size() > 0); i++) step();
    checks++;
    if (alu_q.size() != 0 || md_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d alu and %0d md writes outstanding, expected 0", name, alu_q.size(), md_q.size());
    end
    step();
    step();
  endtask

  task automatic test_reset();
    ctrl_reset_n = 1'b0;
    drive_md(1'b0, 5'd0, 32'd0, 1'b0);
    drive_alu(1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_pending} !== 70'd0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b reg=%0d data=%h pending=%h, expected all 0",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_pending);
    end
    checks++;
    if (md_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_md_ready: got %b expected 1", md_ready);
    end
    step();
    step();
    ctrl_reset_n = 1'b1;
    step();
    checks++;
    if (md_ready !== 1'b1 || ctrl_writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got md_ready=%b we=%b expected md_ready=1 we=0", md_ready, ctrl_writeEnable);
    end
  endtask

  task automatic test_alu_only();
    step();
    drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    drive_alu(1'b0, 5'd0, 32'd0);
    checks++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd5 || data_writeReg !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_only_write: got we=%b reg=%0d data=%h expected we=1 reg=5 data=deadbeef",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    step();
    checks++;
    if (ctrl_writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL alu_only_idle: got we=%b expected 0", ctrl_writeEnable);
    end
    wait_drain("alu_only");
  endtask

  task automatic test_md_drain();
    step();
    drive_md(1'b1, 5'd7, 32'h12345678, 1'b1);
    checks++;
    if (md_ready !== 1'b1) begin
      errors++;
      $display("FAIL md_drain_ready: got %b expected 1", md_ready);
    end
    step();
    drive_md(1'b0, 5'd0, 32'd0, 1'b0);
    checks++;
    if (md_pending !== 32'h0000_0080 || ctrl_writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL md_drain_pending: got pending=%h we=%b expected pending=00000080 we=0", md_pending, ctrl_writeEnable);
    end
    step();
    checks++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd7 || data_writeReg !== 32'h12345678) begin
      errors++;
      $display("FAIL md_drain_write: got we=%b reg=%0d data=%h expected we=1 reg=7 data=12345678",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    step();
    checks++;
    if (md_pending !== 32'd0) begin
      errors++;
      $display("FAIL md_drain_clear: got pending=%h expected 0", md_pending);
    end
    wait_drain("md_drain");
  endtask

  task automatic test_fill_backpressure();
    for (int k = 0; k < 5; k++) begin
      step();
      drive_md(1'b1, 5'(2 + k), 32'h2000 + 32'(k), k < 4);
      drive_alu(1'b1, 5'd1, 32'h1000 + 32'(k));
      checks++;
      if (md_ready !== (k < 4)) begin
        errors++;
        $display("FAIL fill_ready_%0d: got %b expected %b", k, md_ready, k < 4);
      end
    end
    step();
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_md(1'b1, 5'd6, 32'h2004, 1'b0);
    checks++;
    if (md_ready !== 1'b0 || md_pending !== 32'h0000_003C) begin
      errors++;
      $display("FAIL fill_full: got md_ready=%b pending=%h expected md_ready=0 pending=0000003c", md_ready, md_pending);
    end
    step();
    drive_md(1'b1, 5'd6, 32'h2004, 1'b1);
    checks++;
    if (md_ready !== 1'b1 || ctrl_writeReg !== 5'd2) begin
      errors++;
      $display("FAIL fill_resume: got md_ready=%b reg=%0d expected md_ready=1 reg=2", md_ready, ctrl_writeReg);
    end
    step();
    wait_drain("fill");
  endtask

  task automatic test_kill();
    step();
    drive_md(1'b1, 5'd9, 32'h99, 1'b1);
    step();
    drive_md(1'b0, 5'd0, 32'd0, 1'b0);
    drive_alu(1'b1, 5'd9, 32'hA);
    checks++;
    if (md_pending[9] !== 1'b1) begin
      errors++;
      $display("FAIL kill_pending_before: got %b expected 1", md_pending[9]);
    end
    step();
    drive_alu(1'b0, 5'd0, 32'd0);
    checks++;
    if (ctrl_writeReg !== 5'd9 || data_writeReg !== 32'hA || md_pending !== 32'd0) begin
      errors++;
      $display("FAIL kill_edge: got reg=%0d data=%h pending=%h expected reg=9 data=0000000a pending=0",
               ctrl_writeReg, data_writeReg, md_pending);
    end
    step();
    checks++;
    if (ctrl_writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL kill_dead_head: got we=%b expected 0", ctrl_writeEnable);
    end
    // Same-edge kill of the incoming md entry
    step();
    drive_md(1'b1, 5'd10, 32'hBB, 1'b1);
    drive_alu(1'b1, 5'd10, 32'hB);
    step();
    drive_md(1'b0, 5'd0, 32'd0, 1'b0);
    drive_alu(1'b0, 5'd0, 32'd0);
    checks++;
    if (ctrl_writeReg !== 5'd10 || data_writeReg !== 32'hB || md_pending !== 32'd0) begin
      errors++;
      $display("FAIL kill_incoming: got reg=%0d data=%h pending=%h expected reg=10 data=0000000b pending=0",
               ctrl_writeReg, data_writeReg, md_pending);
    end
    wait_drain("kill");
  endtask

  task automatic test_r0();
    for (int i = 0; i < 6; i++) begin
      step();
      drive_md(1'b1, 5'd0, 32'hF00 + 32'(i), 1'b1);
      drive_alu(1'b1, 5'd0, 32'hE00 + 32'(i));
      checks++;
      if (md_ready !== 1'b1 || md_pending !== 32'd0) begin
        errors++;
        $display("FAIL r0_offer_%0d: got md_ready=%b pending=%h expected md_ready=1 pending=0", i, md_ready, md_pending);
      end
    end
    step();
    drive_md(1'b0, 5'd0, 32'd0, 1'b0);
    drive_alu(1'b0, 5'd0, 32'd0);
    checks++;
    if (ctrl_writeEnable !== 1'b0 || md_ready !== 1'b1) begin
      errors++;
      $display("FAIL r0_idle: got we=%b md_ready=%b expected we=0 md_ready=1", ctrl_writeEnable, md_ready);
    end
    // ALU r0 does not block the FIFO from draining
    step();
    drive_md(1'b1, 5'd12, 32'hC, 1'b1);
    step();
    drive_md(1'b0, 5'd0, 32'd0, 1'b0);
    drive_alu(1'b1, 5'd0, 32'h5);
    step();
    drive_alu(1'b0, 5'd0, 32'd0);
    checks++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd12 || data_writeReg !== 32'hC) begin
      errors++;
      $display("FAIL r0_drain: got we=%b reg=%0d data=%h expected we=1 reg=12 data=0000000c",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    wait_drain("r0");
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      step();
      drive_md(1'b1, 5'(20 + k), 32'h3000 + 32'(k), 1'b1);
      drive_alu(1'b1, 5'd3, 32'h4000 + 32'(k));
    end
    step();
    drive_md(1'b0, 5'd0, 32'd0, 1'b0);
    drive_alu(1'b1, 5'd3, 32'h4003);
    checks++;
    if (md_pending !== 32'h0070_0000) begin
      errors++;
      $display("FAIL areset_queued: got pending=%h expected 00700000", md_pending);
    end
    #2;
    ctrl_reset_n = 1'b0;
    alu_q.delete();
    md_q.delete();
    drive_alu(1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_pending} !== 70'd0 || md_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_immediate: got we=%b reg=%0d data=%h pending=%h md_ready=%b expected all 0 md_ready=1",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_pending, md_ready);
    end
    @(posedge clock);
    #1;
    ctrl_reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (ctrl_writeEnable !== 1'b0 || md_pending !== 32'd0 || md_ready !== 1'b1) begin
        errors++;
        $display("FAIL areset_after_%0d: got we=%b reg=%0d pending=%h md_ready=%b expected we=0 pending=0 md_ready=1",
                 i, ctrl_writeEnable, ctrl_writeReg, md_pending, md_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_md_drain();
    test_fill_backpressure();
    test_kill();
    test_r0();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports:
- clock  in  1  rising-edge clock shared with the register file.
- ctrl_reset_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  single-cycle ALU result present this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- md_valid  in  1  multiply/divide result offered.
- md_rd  in  5  multiply/divide destination register.
- md_data  in  32  multiply/divide result.
- md_ready  out  1  block accepts an md result this cycle.
- ctrl_writeEnable  out  1  register-file write enable.
- ctrl_writeReg  out  5  register-file write address.
- data_writeReg  out  32  register-file write data.
- md_pending  out  32  bit k set while a queued md entry targets register k.
REQ-002 The block SHALL have one parameter: DEPTH, default 4, md FIFO entry count (power of two, at least 2).

Function
REQ-003 Write-port outputs SHALL be registered; the register file captures them on the edge ending the cycle in which they are driven.
REQ-004 Each edge SHALL load the output register from exactly one source, in priority order:
- ALU, when alu_valid=1 and alu_rd!=0.
- Otherwise the FIFO head, when the FIFO is non-empty and the head entry is live (the head is popped).
- Otherwise a write-enable of 0.
REQ-005 ALU latency SHALL be 1: an input in cycle N appears on the write port in cycle N+1. The ALU path is never stalled.
REQ-006 An md handshake SHALL occur when md_valid=1 and md_ready=1 at an edge.
REQ-007 md_ready SHALL equal (count < DEPTH), using the count before that edge's pop. A full FIFO therefore refuses even when a pop happens in the same cycle.
REQ-008 An accepted md entry with md_rd=0 SHALL be discarded and not enqueued.
REQ-009 md latency SHALL be at least 2: accepted in cycle N, the earliest write-port appearance is cycle N+2. FIFO order is preserved.
REQ-010 An ALU write to register r SHALL kill every entry with rd=r, both queued entries and the same-edge incoming md entry. Killed entries are marked dead.
REQ-011 A dead head SHALL be popped without asserting write enable and SHALL still consume that edge's FIFO slot.
REQ-012 md_pending SHALL be the combinational OR of one-hot(rd) over all live queued entries. Bit 0 SHALL always be 0.
REQ-013 ALU writes to r0 SHALL be ignored: no write, no kill. The FIFO may drain on that edge.
REQ-014 Count SHALL wrap correctly at the DEPTH boundary. Read and write pointers SHALL wrap modulo DEPTH. A simultaneous push and pop SHALL leave count unchanged.
REQ-015 The FIFO SHALL never overflow or underflow. A pop is attempted only when count>0.

Reset
REQ-016 Asserting ctrl_reset_n=0 SHALL immediately (asynchronously) clear:
- ctrl_writeEnable, ctrl_writeReg and data_writeReg to 0.
- count, pointers and all live bits to 0.
- md_pending to 0.
REQ-017 md_ready SHALL read 1 during and after reset.
REQ-018 Reset asserted mid-operation SHALL drop all queued entries; no queued write SHALL occur after reset.
REQ-019 Reset SHALL be released synchronously to clock by the integrating design. The first edge after release behaves as a normal cycle.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- ALU only: alu (rd=5, data=0xDEADBEEF) in cycle 1 -> cycle 2 shows writeEnable=1, writeReg=5, data=0xDEADBEEF; cycle 3 shows writeEnable=0.
- md drain: md (rd=7, 0x12345678) accepted in cycle 1 with no ALU -> md_pending[7]=1 in cycle 2; write port shows reg 7/0x12345678 in cycle 3; md_pending=0 in cycle 4.
- Fill and backpressure: DEPTH=4 with ALU busy (rd=1) every cycle; offer 5 md results (rd=2..6) -> first 4 accepted, md_ready=0 on the 5th; once ALU goes idle, writes to 2,3,4,5 follow in order, then rd=6 is accepted.
- Kill: md rd=9 queued, then ALU rd=9 data=0xA -> reg 9 written 0xA exactly once; the stale md entry never appears; md_pending[9] clears on the kill edge.
- r0 handling: ALU rd=0 and md rd=0 -> writeEnable never 1; md_ready stays 1; count stays 0.
- Async reset: 3 md entries queued, ctrl_reset_n pulsed low mid-cycle -> all outputs 0 before the next edge; no write to any queued register after release; md_ready=1.
